rng_arbiter: RTL and testbench
==============================

# rng_arbiter

Round-robin controller that shares one free-running 8-bit LFSR among `NREQ` requesters and serializes reseed requests. Each grant delivers one LFSR sample to exactly one requester. A programmable cool-down between samples guarantees that consecutive consumers receive well-separated states. Sits between the `lfsr` instance (whose `load`/`seed` it drives and whose `r_out` it reads) and the game/pattern logic that consumes random bytes. The top level ties the LFSR's `rst_n` to `~rst`.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters (≥2).
- `GAP`, default 8: cool-down cycles after every grant or seed load (≥1).

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous reset, active-high.
- `req`  in  NREQ  per-requester level request; held until matching `gnt` bit pulses.
- `gnt`  out  NREQ  registered one-hot, one-cycle grant pulse.
- `rnd`  out  8  registered random byte; valid in the cycle `gnt` is nonzero, holds afterwards.
- `seed_wr`  in  1  reseed request; level, held until `seed_ack`.
- `seed_data`  in  8  seed value; must be stable while `seed_wr` is high.
- `seed_ack`  out  1  registered one-cycle acknowledge of reseed.
- `lfsr_load`  out  1  registered load strobe to the LFSR.
- `lfsr_seed`  out  8  registered seed to the LFSR.
- `lfsr_q`  in  8  current LFSR state (`r_out`).
- `busy`  out  1  high while in COOL.

## Operation
- The FSM has two states: IDLE and COOL. There is a cool-down counter `cnt` of width clog2(GAP)+1 and a round-robin pointer `ptr` in [0, NREQ-1].
- IDLE, `seed_wr`=1 (seed has priority over `req`):
  - next cycle: `lfsr_load`=1, `lfsr_seed`=`seed_data`, `seed_ack`=1.
  - `cnt`<=GAP-1, go to COOL. `ptr` is unchanged.
- IDLE, `seed_wr`=0, `req`≠0:
  - The winner w is the first set bit scanning upward from `ptr`, with wrap-around.
  - next cycle: `gnt`=one-hot(w), `rnd`=`lfsr_q` as sampled in the IDLE cycle.
  - `ptr`<=(w+1) mod NREQ; `cnt`<=GAP-1; go to COOL.
- IDLE, no requests: stay in IDLE. All pulse outputs are 0.
- COOL: `gnt`, `seed_ack` and `lfsr_load` are 0. `req` and `seed_wr` are ignored (they remain pending).
  - If `cnt`==0, go to IDLE; else `cnt`<=`cnt`-1.
- Seeds are passed through unmodified. The zero-seed → 1 substitution happens in the LFSR, not here.
- A requester that still holds `req` in the cycle after its `gnt` is treated as a new request; it then competes again at the next IDLE.
- `rnd` changes only on a grant; it is not updated by a seed load.

## Timing
- Reset values: state IDLE, `ptr`=0, `cnt`=0, `gnt`=0, `rnd`=0x00, `seed_ack`=0, `lfsr_load`=0, `lfsr_seed`=0x00, `busy`=0.
- Reset wins over all activity, including mid-COOL and the grant cycle itself. In the cycle after `rst` deasserts, the FSM is in IDLE and may sample.
- Grant latency: a request sampled in IDLE cycle t produces `gnt` and `rnd` in cycle t+1.
- COOL occupies cycles t+1..t+GAP. The next IDLE sample is at t+GAP+1, so the minimum sample spacing is GAP+1 cycles (≥GAP+1 LFSR shifts).
- Seed latency: `seed_wr` sampled at t → `lfsr_load`, `seed_ack` at t+1. The LFSR holds the seed in cycle t+2.
- `busy` equals (state==COOL); it is high in cycles t+1..t+GAP.
- Simultaneous `seed_wr` and `req` in IDLE: the seed is served first, and requests are served at the next IDLE.

## Test plan
- Single requester, GAP=8: LFSR reset with `rst`, `req[0]`=1 from cycle 0 (`lfsr_q`=0x01) → `gnt`=0001 at cycle 1 with `rnd`=0x01, again at cycle 10 with `rnd`=0xB1 (LFSR: 01,02,05,0A,15,2B,56,AC,58,B1).
- Round-robin: `req`=1111 held continuously → grants in order 0,1,2,3,0, spaced exactly 9 cycles apart, each pulse exactly one cycle, never two bits set.
- Wrap and skip: `ptr`=3 after serving 2, `req`=0101 → grant 0, then 2, then 0.
- Seed priority: `seed_wr`=1 with `seed_data`=0x00 and `req`=0010 in the same IDLE cycle → `lfsr_load`/`seed_ack` at t+1 with `lfsr_seed`=0x00 and no `gnt`; LFSR reads 0x01 at t+2; `gnt`=0010 at t+10.
- Requests during COOL: `req[2]` raised at cycle 3 of COOL → no `gnt` until IDLE, then `gnt`=0100 at the first post-COOL sample +1; `busy` low only in IDLE.
- Reset mid-operation: assert `rst` during COOL with `ptr`=2 → next cycle all outputs at reset values and `busy`=0; with `req`=1111 → first grant goes to requester 0.

Source files
------------

// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one free-running 8-bit LFSR among NREQ requesters,
// serializing reseeds and enforcing a GAP-cycle cool-down after every grant or load.
module rng_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned GAP  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [7:0]      rnd,
  input  logic            seed_wr,
  input  logic [7:0]      seed_data,
  output logic            seed_ack,
  output logic            lfsr_load,
  output logic [7:0]      lfsr_seed,
  input  logic [7:0]      lfsr_q,
  output logic            busy
);

  localparam int unsigned CW = $clog2(GAP) + 1;
  localparam int unsigned PW = $clog2(NREQ);

  typedef enum logic [0:0] {StIdle, StCool} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [7:0]        rnd_q, rnd_d;
  logic              ack_q, ack_d;
  logic              load_q, load_d;
  logic [7:0]        seed_q, seed_d;

  logic [2*NREQ-1:0] req_rot;
  logic              found;
  logic [PW:0]       win_ext;
  logic [PW:0]       ptr_inc;
  logic [PW-1:0]     win;
  logic [PW-1:0]     ptr_nxt;

  // Rotate so that bit 0 is the requester at ptr; the first set bit is the winner.
  assign req_rot = {req, req} >> ptr_q;

  always_comb begin
    found   = 1'b0;
    win_ext = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!found && req_rot[i]) begin
        found   = 1'b1;
        win_ext = {1'b0, ptr_q} + (PW+1)'(i);
      end
    end
    if (win_ext >= (PW+1)'(NREQ)) begin
      win_ext = win_ext - (PW+1)'(NREQ);
    end
    win     = win_ext[PW-1:0];
    ptr_inc = win_ext + (PW+1)'(1);
    ptr_nxt = (ptr_inc == (PW+1)'(NREQ)) ? '0 : ptr_inc[PW-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    rnd_d   = rnd_q;
    ack_d   = 1'b0;
    load_d  = 1'b0;
    seed_d  = seed_q;
    case (state_q)
      StIdle: begin
        if (seed_wr) begin
          load_d  = 1'b1;
          ack_d   = 1'b1;
          seed_d  = seed_data;
          cnt_d   = CW'(GAP - 1);
          state_d = StCool;
        end else if (found) begin
          gnt_d   = NREQ'(1) << win;
          rnd_d   = lfsr_q;
          ptr_d   = ptr_nxt;
          cnt_d   = CW'(GAP - 1);
          state_d = StCool;
        end
      end
      StCool: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      rnd_q   <= '0;
      ack_q   <= 1'b0;
      load_q  <= 1'b0;
      seed_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      rnd_q   <= rnd_d;
      ack_q   <= ack_d;
      load_q  <= load_d;
      seed_q  <= seed_d;
    end
  end

  assign gnt       = gnt_q;
  assign rnd       = rnd_q;
  assign seed_ack  = ack_q;
  assign lfsr_load = load_q;
  assign lfsr_seed = seed_q;
  assign busy      = (state_q == StCool);

endmodule

// File: tb/tb_rng_arbiter.sv
// Self-checking bench for rng_arbiter: directed scenarios plus randomized traffic checked
// against a time-based reference model; an LFSR model supplies lfsr_q.
module tb_rng_arbiter;

  localparam int NREQ = 4;
  localparam int GAP  = 8;
  localparam int W    = NREQ + 19;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [7:0]      rnd;
  logic            seed_wr;
  logic [7:0]      seed_data;
  logic            seed_ack;
  logic            lfsr_load;
  logic [7:0]      lfsr_seed;
  logic [7:0]      lfsr_q;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  rng_arbiter #(.NREQ(NREQ), .GAP(GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .rnd       (rnd),
    .seed_wr   (seed_wr),
    .seed_data (seed_data),
    .seed_ack  (seed_ack),
    .lfsr_load (lfsr_load),
    .lfsr_seed (lfsr_seed),
    .lfsr_q    (lfsr_q),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // LFSR environment: sequence 01,02,05,0A,15,2B,56,AC,58,B1,...; zero seed becomes 1.
  logic [7:0] lfsr;
  always @(posedge clk) begin
    if (rst) lfsr <= 8'h01;
    else if (lfsr_load) lfsr <= (lfsr_seed == 8'h00) ? 8'h01 : lfsr_seed;
    else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[1]};
  end
  assign lfsr_q = lfsr;

  // Reference model: the arbiter may sample only at cycles >= m_free.
  int              cur = 0;
  int              m_ptr = 0;
  int              m_free = 0;
  logic [NREQ-1:0] e_gnt;
  logic [7:0]      e_rnd;
  logic            e_ack;
  logic            e_load;
  logic [7:0]      e_seed;
  logic            e_busy;

  function automatic logic [W-1:0] obs();
    return {gnt, rnd, seed_ack, lfsr_load, lfsr_seed, busy};
  endfunction

  function automatic logic [W-1:0] expv();
    return {e_gnt, e_rnd, e_ack, e_load, e_seed, e_busy};
  endfunction

  task automatic step();
    int w;
    e_gnt  = '0;
    e_ack  = 1'b0;
    e_load = 1'b0;
    if (rst) begin
      m_ptr  = 0;
      m_free = 0;
      e_rnd  = 8'h00;
      e_seed = 8'h00;
    end else if (cur >= m_free) begin
      if (seed_wr) begin
        e_ack  = 1'b1;
        e_load = 1'b1;
        e_seed = seed_data;
        m_free = cur + GAP + 1;
      end else if (req != '0) begin
        w = -1;
        for (int i = 0; i < NREQ; i++) begin
          if (w < 0 && req[(m_ptr + i) % NREQ]) w = (m_ptr + i) % NREQ;
        end
        e_gnt[w] = 1'b1;
        e_rnd    = lfsr;
        m_ptr    = (w + 1) % NREQ;
        m_free   = cur + GAP + 1;
      end
    end
    e_busy = !rst && (cur + 1 < m_free);
    @(posedge clk);
    #1;
    cur = cur + 1;
  endtask

  task automatic do_reset(output int base);
    rst = 1'b1;
    step();
    rst = 1'b0;
    base = cur;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req       = 4'b1011;
    seed_wr   = 1'b1;
    seed_data = 8'h5A;
    for (int n = 0; n < 3; n++) begin
      step();
      checks++;
      if (obs() !== {NREQ'(0), 8'h00, 1'b0, 1'b0, 8'h00, 1'b0}) begin
        failures++;
        $display("FAIL reset n=%0d got=%h want=0", n, obs());
      end
    end
    req     = '0;
    seed_wr = 1'b0;
  endtask

  task automatic test_single();
    int base;
    do_reset(base);
    req = 4'b0001;
    while (cur - base < 12) begin
      step();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL single_model cyc=%0d got=%h want=%h", cur - base, obs(), expv());
      end
      if (cur - base == 1 || cur - base == 10) begin
        checks++;
        if (gnt !== 4'b0001 || rnd !== ((cur - base == 1) ? 8'h01 : 8'hB1)) begin
          failures++;
          $display("FAIL single_grant cyc=%0d gnt=%b rnd=%h", cur - base, gnt, rnd);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_round_robin();
    int base;
    int ids[$];
    int cyc[$];
    do_reset(base);
    req = 4'b1111;
    for (int n = 0; n < 40; n++) begin
      step();
      checks++;
      if (obs() !== expv() || !$onehot0(gnt)) begin
        failures++;
        $display("FAIL rr_model cyc=%0d got=%h want=%h", cur - base, obs(), expv());
      end
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) begin
          ids.push_back(i);
          cyc.push_back(cur - base);
        end
      end
    end
    checks++;
    if (ids.size() != 5 || ids[0] != 0 || ids[1] != 1 || ids[2] != 2 || ids[3] != 3
        || ids[4] != 0 || cyc[0] != 1 || cyc[4] - cyc[0] != 4 * (GAP + 1)
        || cyc[1] - cyc[0] != GAP + 1) begin
      failures++;
      $display("FAIL rr_order n=%0d ids=%p cycles=%p want ids 0,1,2,3,0 spaced %0d",
               ids.size(), ids, cyc, GAP + 1);
    end
    req = '0;
  endtask

  task automatic test_wrap_skip();
    int base;
    int ids[$];
    do_reset(base);
    req = 4'b0100;
    for (int n = 0; n < 30; n++) begin
      step();
      if (n == 0) req = 4'b0101;
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL wrap_model cyc=%0d got=%h want=%h", cur - base, obs(), expv());
      end
      for (int i = 0; i < NREQ; i++) if (gnt[i]) ids.push_back(i);
    end
    checks++;
    if (ids.size() != 4 || ids[0] != 2 || ids[1] != 0 || ids[2] != 2 || ids[3] != 0) begin
      failures++;
      $display("FAIL wrap_order ids=%p want 2,0,2,0", ids);
    end
    req = '0;
  endtask

  task automatic test_seed_priority();
    int base;
    do_reset(base);
    seed_wr   = 1'b1;
    seed_data = 8'h00;
    req       = 4'b0010;
    while (cur - base < 12) begin
      step();
      if (seed_ack) seed_wr = 1'b0;
      if (gnt[1]) req = '0;
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL seed_model cyc=%0d got=%h want=%h", cur - base, obs(), expv());
      end
      if (cur - base == 1) begin
        checks++;
        if (lfsr_load !== 1'b1 || seed_ack !== 1'b1 || lfsr_seed !== 8'h00 || gnt !== '0) begin
          failures++;
          $display("FAIL seed_load load=%b ack=%b seed=%h gnt=%b", lfsr_load, seed_ack,
                   lfsr_seed, gnt);
        end
      end
      if (cur - base == 2) begin
        checks++;
        if (lfsr_q !== 8'h01) begin
          failures++;
          $display("FAIL seed_lfsr got=%h want=01", lfsr_q);
        end
      end
      if (cur - base == 10) begin
        checks++;
        if (gnt !== 4'b0010) begin
          failures++;
          $display("FAIL seed_then_gnt got=%b want=0010", gnt);
        end
      end
    end
  endtask

  task automatic test_cool_requests();
    int base;
    logic want_busy;
    do_reset(base);
    req = 4'b0001;
    while (cur - base < 14) begin
      step();
      if (cur - base == 1) req = '0;
      if (cur - base == 3) req = 4'b0100;
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL cool_model cyc=%0d got=%h want=%h", cur - base, obs(), expv());
      end
      want_busy = (cur - base >= 1 && cur - base <= 8) || (cur - base >= 10);
      checks++;
      if (busy !== want_busy || gnt !== ((cur - base == 1) ? 4'b0001 :
                                         (cur - base == 10) ? 4'b0100 : 4'b0000)) begin
        failures++;
        $display("FAIL cool_gnt cyc=%0d gnt=%b busy=%b want_busy=%b", cur - base, gnt, busy,
                 want_busy);
      end
      if (cur - base == 10) req = '0;
    end
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset(base);
    req = 4'b0010;
    while (cur - base < 4) begin
      step();
      if (cur - base == 1) req = 4'b1111;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (obs() !== {NREQ'(0), 8'h00, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid got=%h want=0", obs());
    end
    step();
    checks++;
    if (gnt !== 4'b0001 || obs() !== expv()) begin
      failures++;
      $display("FAIL reset_mid_gnt gnt=%b want=0001 got=%h model=%h", gnt, obs(), expv());
    end
    req = '0;
    while (busy && cur - base < 40) step();
  endtask

  task automatic test_random();
    int base;
    do_reset(base);
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      step();
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL random n=%0d got=%h want=%h", n, obs(), expv());
      end
      if (e_ack) seed_wr = 1'b0;
      req = req & ~(e_gnt & NREQ'($urandom));
      if ($urandom_range(0, 3) == 0) req = req | (NREQ'(1) << $urandom_range(0, NREQ - 1));
      if (!seed_wr && $urandom_range(0, 29) == 0) begin
        seed_wr   = 1'b1;
        seed_data = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      end
    end
    rst     = 1'b0;
    req     = '0;
    seed_wr = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    seed_wr   = 1'b0;
    seed_data = 8'h00;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_skip();
    test_seed_priority();
    test_cool_requests();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
